// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector-buffer feeder: state encoding,
// sector geometry and a small helper for byte-lane arithmetic.
package sd_pkg;

  localparam int SD_SECTOR_BYTES     = 512;
  localparam int SD_WORD_W           = 32;
  localparam int SD_WORDS_PER_SECTOR = 128;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    WRITE    = 3'd2,
    WAIT_END = 3'd3,
    DONE     = 3'd4
  } sd_state_t;

  // Number of bytes packed into one buffer word.
  function automatic int bytes_per_word();
    return SD_WORD_W / 8;
  endfunction

endpackage

// File: rtl/sd_word_packer.sv
// sd_word_packer: packs the SD SPI read byte stream into 32-bit words
// (byte k of a word lands in bits [8k+7:8k]) and writes them to slots
// 0..WORDS_PER_SECTOR-1 of the sector buffer using the we/write_end
// handshake, pulsing sector_done after the last slot.
// Optional feature macro: SD_PACK_TIMEOUT_EN -- bounds the wait for
// write_end to WAIT_TIMEOUT cycles and raises a sticky timeout_err.
module sd_word_packer
  import sd_pkg::*;
#(
  parameter int WORDS_PER_SECTOR = SD_WORDS_PER_SECTOR,
  parameter int ADDR_W           = 7,
  parameter int WAIT_TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [ADDR_W-1:0]    addr,
  output logic                 sd_buffer_we,
  output logic [SD_WORD_W-1:0] sd_buffer_data_in,
  input  logic                 sd_buffer_write_end,
  output logic                 sector_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [1:0]        LAST_BYTE = 2'(bytes_per_word() - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_SECTOR - 1);

  // Elaboration-time sanity checks on the parameter set.
  generate
    if ((1 << ADDR_W) < WORDS_PER_SECTOR) begin : g_bad_addr_w
      $error("ADDR_W too narrow for WORDS_PER_SECTOR");
    end
    if (WAIT_TIMEOUT < 1) begin : g_bad_timeout
      $error("WAIT_TIMEOUT must be at least 1");
    end
    if (SD_SECTOR_BYTES != SD_WORDS_PER_SECTOR * bytes_per_word()) begin : g_bad_geometry
      $error("sector geometry inconsistent");
    end
  endgenerate

  sd_state_t              state_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic [1:0]             byte_cnt_reg;
  logic [SD_WORD_W-1:0]   data_reg;
  logic                   byte_ready_reg;
  logic                   we_reg;
  logic                   sector_done_reg;
  logic                   busy_reg;
  logic                   byte_take;

`ifdef SD_PACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);
  logic [TMO_W-1:0]       tmo_cnt_reg;
  logic                   timeout_err_reg;
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  // byte_ready_reg is high only in COLLECT, so this is the transfer strobe.
  assign byte_take = byte_valid & byte_ready_reg;

  assign byte_ready        = byte_ready_reg;
  assign addr              = addr_reg;
  assign sd_buffer_we      = we_reg;
  assign sd_buffer_data_in = data_reg;
  assign sector_done       = sector_done_reg;
  assign busy              = busy_reg;

  // Packer FSM with registered outputs; abort overrides every transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      byte_cnt_reg    <= '0;
      data_reg        <= '0;
      byte_ready_reg  <= 1'b0;
      we_reg          <= 1'b0;
      sector_done_reg <= 1'b0;
      busy_reg        <= 1'b0;
`ifdef SD_PACK_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else if (abort) begin
      // Partial word is simply never written; data_reg keeps stale bytes.
      state_reg       <= IDLE;
      addr_reg        <= '0;
      byte_cnt_reg    <= '0;
      byte_ready_reg  <= 1'b0;
      we_reg          <= 1'b0;
      sector_done_reg <= 1'b0;
      busy_reg        <= 1'b0;
`ifdef SD_PACK_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
`endif
    end else begin
      we_reg          <= 1'b0;
      sector_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg      <= COLLECT;
            addr_reg       <= '0;
            byte_cnt_reg   <= '0;
            byte_ready_reg <= 1'b1;
            busy_reg       <= 1'b1;
`ifdef SD_PACK_TIMEOUT_EN
            timeout_err_reg <= 1'b0;
`endif
          end
        end
        COLLECT: begin
          if (byte_take) begin
            data_reg[{byte_cnt_reg, 3'b000} +: 8] <= byte_in;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == LAST_BYTE) begin
              state_reg      <= WRITE;
              byte_ready_reg <= 1'b0;
              we_reg         <= 1'b1;
            end
          end
        end
        WRITE: begin
          state_reg <= WAIT_END;
`ifdef SD_PACK_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
        end
        WAIT_END: begin
          // addr/data stay frozen here while the buffer prepares its write.
          if (sd_buffer_write_end) begin
            if (addr_reg == LAST_ADDR) begin
              state_reg       <= DONE;
              sector_done_reg <= 1'b1;
            end else begin
              state_reg      <= COLLECT;
              addr_reg       <= addr_reg + 1'b1;
              byte_ready_reg <= 1'b1;
            end
          end
`ifdef SD_PACK_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_W'(WAIT_TIMEOUT - 1)) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end
        DONE: begin
          state_reg <= IDLE;
          addr_reg  <= '0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg      <= IDLE;
          addr_reg       <= '0;
          byte_ready_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sd_word_packer.md
Name: sd_word_packer

Overview:
- Upstream feeder of the SD sector buffer.
- Takes the byte stream from the SD SPI read path (512 data bytes per sector) and packs each 4 bytes into one 32-bit word.
- Writes words to the buffer at slot addresses 0..127 using the buffer's we / write_end handshake.
- Pulses sector_done once the full 4096-bit sector has been written.

Parameters:
- WORDS_PER_SECTOR, 128, number of 32-bit words per sector; the last slot is WORDS_PER_SECTOR-1.
- ADDR_W, 7, width of the slot address; must satisfy 2^ADDR_W >= WORDS_PER_SECTOR.
- WAIT_TIMEOUT, 16, maximum cycles spent in WAIT_END before error (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; when low at a rising clk edge the block returns to reset state
- start  in  1  one-cycle pulse, begins a new sector; ignored unless in IDLE
- abort  in  1  drop the current sector; return to IDLE next cycle, no sector_done
- byte_in  in  8  received data byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  block accepts byte_in this cycle; a transfer occurs when byte_valid & byte_ready
- addr  out  ADDR_W  buffer slot address
- sd_buffer_we  out  1  write request to the buffer
- sd_buffer_data_in  out  32  packed word to the buffer
- sd_buffer_write_end  in  1  buffer completion pulse
- sector_done  out  1  one-cycle pulse after the last slot is written
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky error flag (optional feature only; tied 0 otherwise)

Behaviour:
Reset values:
- All outputs 0, addr 0, byte counter 0, state IDLE.

States: IDLE, COLLECT, WRITE, WAIT_END, DONE.
- IDLE: byte_ready 0. start -> COLLECT; addr := 0; byte counter := 0.
- COLLECT: byte_ready 1.
  - On each transfer, byte k (k = 0..3, arrival order) is stored in sd_buffer_data_in[8k+7:8k], bits unmodified.
  - The byte counter increments, 2-bit wrapping.
  - The transfer with k = 3 -> WRITE.
- WRITE: sd_buffer_we = 1 for exactly this one cycle; byte_ready 0 -> WAIT_END.
- WAIT_END: we 0; byte_ready 0; addr and data held stable, because the buffer samples them during its prepare cycle.
  - write_end = 1 and addr == WORDS_PER_SECTOR-1 -> DONE.
  - write_end = 1 and addr != WORDS_PER_SECTOR-1 -> COLLECT, addr += 1.
- DONE: sector_done = 1 for one cycle; addr := 0 -> IDLE.

Latency:
- 4th byte accepted at cycle t: we high at t+1, write_end expected at t+3.
- COLLECT with byte_ready high resumes at t+4.
- For the final word, sector_done is high at t+4.

Boundary conditions:
- start when not in IDLE: ignored.
- start and byte_valid in the same cycle: the byte is not consumed.
- byte_valid while byte_ready is 0: byte held by the source, not dropped.
- write_end seen outside WAIT_END: ignored.
- abort takes priority over every transition. The partial word is discarded and addr returns to 0. Words already in the buffer are left as is.
- reset low takes priority over abort.
- addr never exceeds WORDS_PER_SECTOR-1; it wraps to 0 only via DONE, abort or reset.
- sd_buffer_data_in is not cleared between words; the upper bytes keep stale data until overwritten.

Optional Feature:
Macro SD_PACK_TIMEOUT_EN.
- Defined: a counter runs in WAIT_END.
  - If WAIT_TIMEOUT cycles pass without write_end: go to IDLE, set timeout_err = 1, addr := 0, no sector_done.
  - timeout_err clears only on reset or on the next accepted start.
- Undefined:
  - No counter; WAIT_END waits indefinitely.
  - timeout_err is constant 0.

Decomposition:
- Shared package sd_pkg:
  - State encoding constants (IDLE = 0, COLLECT = 1, WRITE = 2, WAIT_END = 3, DONE = 4).
  - SD_SECTOR_BYTES = 512, SD_WORD_W = 32, SD_WORDS_PER_SECTOR = 128.
- No sub-module needed; a single module of FSM, byte counter, word register and address counter. The timeout counter sits inline under the macro.

Test Plan:
- Reset low for 2 cycles, then high -> all outputs 0, busy 0, byte_ready 0.
- start, then bytes 0x11,0x22,0x33,0x44 back-to-back; buffer model returns write_end 2 cycles after we.
  - we high exactly 1 cycle with data 0x44332211 and addr 0.
  - byte_ready returns 4 cycles after the 4th byte.
- Stream 512 bytes with random byte_valid gaps.
  - 128 writes at addr 0..127, sector_done one pulse after the 128th write_end, then busy 0 and addr 0.
  - Buffer contents match the byte sequence.
- Assert abort after 3 bytes of word 5 -> IDLE next cycle, addr 0, no we, no sector_done.
  - A following start and a full sector complete normally.
- start pulse while busy, and byte_valid held high during WAIT_END -> no state change, no extra byte consumed.
- (SD_PACK_TIMEOUT_EN) buffer model never returns write_end.
  - After 16 cycles in WAIT_END: timeout_err 1, busy 0, no sector_done.
  - Next start clears timeout_err.
